// File: rtl/kws_inference_sequencer_pkg.sv
// Shared definitions for the keyword-spotting inference sequencer.
//   - state_t      : sequencer FSM state encoding
//   - L_*          : layer indices as used on layer_start / layer_done / err_layer
//   - P_*          : parameter-layer indices as used on cfg_mask / load_* strobes
//   - layer_name() : layer index to an 8-character ASCII tag, for debug displays
package kws_inference_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_CFG_ACK = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_RESULT  = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    localparam logic [2:0] L_CONV1   = 3'd0;
    localparam logic [2:0] L_CONV2   = 3'd1;
    localparam logic [2:0] L_MAXPOOL = 3'd2;
    localparam logic [2:0] L_FC1     = 3'd3;
    localparam logic [2:0] L_FC2     = 3'd4;
    localparam logic [2:0] L_SOFTMAX = 3'd5;

    localparam logic [1:0] P_CONV1 = 2'd0;
    localparam logic [1:0] P_CONV2 = 2'd1;
    localparam logic [1:0] P_FC1   = 2'd2;
    localparam logic [1:0] P_FC2   = 2'd3;

    // Names are space-padded to exactly 8 characters so they fill the vector.
    function automatic logic [63:0] layer_name(input logic [2:0] idx);
        case (idx)
            L_CONV1:   layer_name = "conv1   ";
            L_CONV2:   layer_name = "conv2   ";
            L_MAXPOOL: layer_name = "maxpool ";
            L_FC1:     layer_name = "fc1     ";
            L_FC2:     layer_name = "fc2     ";
            L_SOFTMAX: layer_name = "softmax ";
            default:   layer_name = "invalid ";
        endcase
    endfunction

endpackage

// File: rtl/kws_sat_counter.sv
// Saturating up-counter (used for the dropped-frame count).
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : add one this cycle unless already at all ones
//   count : registered count value
module kws_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/kws_inference_sequencer.sv
// Control FSM for the CNN keyword-spotting accelerator.
// Loads per-layer weights/biases on request, then runs one six-layer
// inference (conv1, conv2, maxpool, fc1, fc2, softmax) per accepted frame.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   cfg_req, cfg_mask       : parameter load request and layer mask (IDLE only)
//   cfg_ack                 : one-cycle pulse when the load sequence completes
//   load_weights/biases     : one-hot single-cycle load strobes
//   frame_valid             : MFCC frame ready pulse
//   layer_start/layer_done  : per-layer start pulse / completion pulse
//   softmax_in              : class vector, valid with layer_done[softmax]
//   kws_result, kws_valid   : held result and its one-cycle valid pulse
//   abort                   : cancel the running inference
//   busy, error, err_layer  : status; err_layer holds the last timed-out layer
//   err_clear               : leave ERROR
//   drop_count              : saturating count of rejected frames
// Every output is a register; registered outputs are computed from the
// next state so they line up with the state they belong to.
module kws_inference_sequencer
    import kws_inference_sequencer_pkg::*;
#(
    parameter int NUM_KEYWORDS     = 10,
    parameter int NUM_LAYERS       = 6,
    parameter int NUM_PARAM_LAYERS = 4,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_req,
    input  logic [NUM_PARAM_LAYERS-1:0] cfg_mask,
    output logic                        cfg_ack,
    output logic [NUM_PARAM_LAYERS-1:0] load_weights,
    output logic [NUM_PARAM_LAYERS-1:0] load_biases,
    input  logic                        frame_valid,
    output logic [NUM_LAYERS-1:0]       layer_start,
    input  logic [NUM_LAYERS-1:0]       layer_done,
    input  logic [NUM_KEYWORDS-1:0]     softmax_in,
    output logic [NUM_KEYWORDS-1:0]     kws_result,
    output logic                        kws_valid,
    input  logic                        abort,
    output logic                        busy,
    output logic                        error,
    output logic [2:0]                  err_layer,
    input  logic                        err_clear,
    output logic [7:0]                  drop_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Isolates the lowest set bit: the next parameter layer to load.
    function automatic logic [NUM_PARAM_LAYERS-1:0] lowest_bit(input logic [NUM_PARAM_LAYERS-1:0] v);
        lowest_bit = v & (~v + NUM_PARAM_LAYERS'(1));
    endfunction

    state_t                      state_reg, state_next;
    logic [2:0]                  idx_reg, idx_next;
    logic [NUM_PARAM_LAYERS-1:0] pend_reg, pend_next;
    logic [NUM_PARAM_LAYERS-1:0] configured_reg, configured_next;
    logic [TW-1:0]               timer_reg;
    logic [NUM_KEYWORDS-1:0]     result_hold_reg, result_hold_next;

    logic [NUM_PARAM_LAYERS-1:0] load_weights_reg, load_weights_next;
    logic [NUM_PARAM_LAYERS-1:0] load_biases_reg, load_biases_next;
    logic                        cfg_ack_reg, cfg_ack_next;
    logic [NUM_LAYERS-1:0]       layer_start_reg, layer_start_next;
    logic [NUM_KEYWORDS-1:0]     kws_result_reg, kws_result_next;
    logic                        kws_valid_reg, kws_valid_next;
    logic                        busy_reg, busy_next;
    logic                        error_reg, error_next;
    logic [2:0]                  err_layer_reg, err_layer_next;

    logic                        done_cur;
    logic                        accept;
    logic [NUM_LAYERS-1:0]       start_onehot;

    assign done_cur = layer_done[idx_reg];
    // cfg_req has priority, so a frame in the same cycle is rejected.
    assign accept   = (state_reg == ST_IDLE) && frame_valid && !cfg_req && (&configured_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_start_dec
            assign start_onehot[gi] = (idx_next == 3'(gi));
        end
    endgenerate

    // State register and FSM-owned datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            pend_reg        <= '0;
            configured_reg  <= '0;
            timer_reg       <= '0;
            result_hold_reg <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            pend_reg        <= pend_next;
            configured_reg  <= configured_next;
            // Zero outside WAIT, so every entry into WAIT starts from zero.
            timer_reg       <= (state_reg == ST_WAIT) ? timer_reg + TW'(1) : '0;
            result_hold_reg <= result_hold_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        pend_next        = pend_reg;
        configured_next  = configured_reg;
        result_hold_next = result_hold_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_req) begin
                    pend_next       = cfg_mask;
                    configured_next = configured_reg | cfg_mask;
                    state_next      = (cfg_mask == '0) ? ST_CFG_ACK : ST_LOAD_W;
                end else if (accept) begin
                    idx_next   = L_CONV1;
                    state_next = ST_START;
                end
            end
            ST_LOAD_W:  state_next = ST_LOAD_B;
            ST_LOAD_B: begin
                pend_next  = pend_reg & ~lowest_bit(pend_reg);
                state_next = (pend_next == '0) ? ST_CFG_ACK : ST_LOAD_W;
            end
            ST_CFG_ACK: state_next = ST_IDLE;
            ST_START:   state_next = abort ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (done_cur) begin
                    // A done in the final timer cycle still counts.
                    if (idx_reg == L_SOFTMAX) begin
                        result_hold_next = softmax_in;
                        state_next       = ST_RESULT;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ST_START;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ST_ERROR;
                end
            end
            ST_RESULT:  state_next = ST_IDLE;
            ST_ERROR:   state_next = err_clear ? ST_IDLE : ST_ERROR;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the output registers.
    always_comb begin
        load_weights_next = (state_next == ST_LOAD_W) ? lowest_bit(pend_next) : '0;
        load_biases_next  = (state_next == ST_LOAD_B) ? lowest_bit(pend_next) : '0;
        cfg_ack_next      = (state_next == ST_CFG_ACK);
        layer_start_next  = (state_next == ST_START) ? start_onehot : '0;
        kws_valid_next    = (state_reg == ST_RESULT) && !abort;
        kws_result_next   = kws_valid_next ? result_hold_reg : kws_result_reg;
        busy_next         = (state_next != ST_IDLE);
        error_next        = (state_next == ST_ERROR);
        err_layer_next    = ((state_reg == ST_WAIT) && (state_next == ST_ERROR)) ? idx_reg : err_layer_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_weights_reg <= '0;
            load_biases_reg  <= '0;
            cfg_ack_reg      <= 1'b0;
            layer_start_reg  <= '0;
            kws_result_reg   <= '0;
            kws_valid_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            error_reg        <= 1'b0;
            err_layer_reg    <= '0;
        end else begin
            load_weights_reg <= load_weights_next;
            load_biases_reg  <= load_biases_next;
            cfg_ack_reg      <= cfg_ack_next;
            layer_start_reg  <= layer_start_next;
            kws_result_reg   <= kws_result_next;
            kws_valid_reg    <= kws_valid_next;
            busy_reg         <= busy_next;
            error_reg        <= error_next;
            err_layer_reg    <= err_layer_next;
        end
    end

    kws_sat_counter #(.W(8)) u_drop_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_valid && !accept),
        .count (drop_count)
    );

    assign load_weights = load_weights_reg;
    assign load_biases  = load_biases_reg;
    assign cfg_ack      = cfg_ack_reg;
    assign layer_start  = layer_start_reg;
    assign kws_result   = kws_result_reg;
    assign kws_valid    = kws_valid_reg;
    assign busy         = busy_reg;
    assign error        = error_reg;
    assign err_layer    = err_layer_reg;

endmodule
